xyz_convert_scheduler: RTL and testbench

- Shares the single combinational RGB→XYZ datapath (normalizer plus matrix, 64-bit IEEE-754 double operands) between up to NUM_REQ pixel requesters.
- Arbitrates round-robin and presents the winning R/G/B operands to the datapath, holding them stable for SETTLE_CYCLES (multicycle path).
- Captures X/Y/Z and returns them with the requester id over a valid/ready response port.
- Sits between the pixel-fetch clients (skin-detect path, host debug path) and the datapath instance in the top-level integration.

---
 rtl/xyz_sched_pkg.sv | 18 +
 rtl/xyz_convert_scheduler_rr_arbiter.sv | 46 ++++
 rtl/xyz_convert_scheduler.sv | 170 +++++++++++++++++
 tb/tb_xyz_convert_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xyz_sched_pkg.sv
// Shared types and constants for the RGB->XYZ conversion scheduler.
//   state_t  : scheduler FSM states
//   DBL_W    : IEEE-754 double operand width
//   DBL_ONE / DBL_HALF : handy double constants (1.0 and 0.5)
package xyz_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DBL_W = 64;

  localparam logic [63:0] DBL_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] DBL_HALF = 64'h3FE0000000000000;

endpackage

// File: rtl/xyz_convert_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first asserted
// request found searching upward from ptr, modulo NUM_REQ.
//   req    : request vector
//   ptr    : requester with highest priority this cycle
//   grant  : one-hot grant, all zero when nothing requests
//   winner : index of the granted requester (0 when none)
//   any    : at least one request asserted
module rr_arbiter
#(
  parameter int NUM_REQ = 2
)
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         winner,
  output logic               any
);

  // Priority search in rotated order; the inner loop keeps every select constant.
  always_comb begin : search
    logic [2:0] pos_v;
    grant  = '0;
    winner = 2'd0;
    any    = 1'b0;
    pos_v  = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_v = {1'b0, ptr} + 3'(k);
      if (pos_v >= 3'(NUM_REQ)) begin
        pos_v = pos_v - 3'(NUM_REQ);
      end else begin
        pos_v = pos_v;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (pos_v[1:0] == 2'(i))) begin
          grant[i] = 1'b1;
          winner   = 2'(i);
          any      = 1'b1;
        end else begin
          any = any;
        end
      end
    end
  end

endmodule

// File: rtl/xyz_convert_scheduler.sv
// Shares one combinational RGB->XYZ datapath between NUM_REQ requesters.
// A round-robin winner's operands are registered onto dp_R/G/B and held for
// SETTLE_CYCLES clocks, then dp_X/Y/Z is captured and returned with the
// requester id on a valid/ready response port. One request in flight at most.
//   Clk, Reset_n          : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot or zero)
//   req_R/G/B             : packed operands, slice i belongs to requester i
//   dp_R/G/B, dp_X/Y/Z    : datapath operands out, results in
//   rsp_valid/ready, rsp_id, rsp_X/Y/Z : response port
//   busy                  : FSM not in IDLE
//   conv_count            : completed responses, wrapping
module xyz_convert_scheduler
  import xyz_sched_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
)
(
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*64-1:0]    req_R,
  input  logic [NUM_REQ*64-1:0]    req_G,
  input  logic [NUM_REQ*64-1:0]    req_B,
  output logic [63:0]              dp_R,
  output logic [63:0]              dp_G,
  output logic [63:0]              dp_B,
  input  logic [63:0]              dp_X,
  input  logic [63:0]              dp_Y,
  input  logic [63:0]              dp_Z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [63:0]              rsp_X,
  output logic [63:0]              rsp_Y,
  output logic [63:0]              rsp_Z,
  output logic                     busy,
  output logic [CNT_W-1:0]         conv_count
);

  state_t             state_r, state_nxt_s;
  logic [1:0]         rr_ptr_r;
  logic [3:0]         cnt_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [1:0]         winner_s;
  logic               any_s;
  logic               accept_s;
  logic               rsp_hs_s;
  logic [63:0]        sel_r_s, sel_g_s, sel_b_s;
  logic [63:0]        dp_r_r, dp_g_r, dp_b_r;
  logic [63:0]        rsp_x_r, rsp_y_r, rsp_z_r;
  logic [1:0]         rsp_id_r;
  logic               rsp_valid_r;
  logic [CNT_W-1:0]   conv_count_r;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .grant  (grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Ready is one-hot on the winner, so any valid in IDLE is a handshake.
  assign accept_s = (state_r == IDLE) && any_s;
  assign rsp_hs_s = (state_r == RESP) && rsp_valid_r && rsp_ready;

  // Winner operand mux.
  always_comb begin
    sel_r_s = '0;
    sel_g_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_s == 2'(i)) begin
        sel_r_s = req_R[i*DBL_W +: DBL_W];
        sel_g_s = req_G[i*DBL_W +: DBL_W];
        sel_b_s = req_B[i*DBL_W +: DBL_W];
      end else begin
        sel_r_s = sel_r_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = any_s ? SETTLE : IDLE;
      SETTLE:  state_nxt_s = (cnt_r == 4'd0) ? RESP : SETTLE;
      RESP:    state_nxt_s = rsp_hs_s ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: grants only while idle.
  always_comb begin
    req_ready = '0;
    case (state_r)
      IDLE:    req_ready = grant_s;
      default: req_ready = '0;
    endcase
  end

  // Operand registers, round-robin pointer and settle counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dp_r_r   <= 64'd0;
      dp_g_r   <= 64'd0;
      dp_b_r   <= 64'd0;
      rsp_id_r <= 2'd0;
      rr_ptr_r <= 2'd0;
      cnt_r    <= 4'd0;
    end else if (accept_s) begin
      dp_r_r   <= sel_r_s;
      dp_g_r   <= sel_g_s;
      dp_b_r   <= sel_b_s;
      rsp_id_r <= winner_s;
      rr_ptr_r <= (winner_s == 2'(NUM_REQ-1)) ? 2'd0 : winner_s + 2'd1;
      cnt_r    <= 4'(SETTLE_CYCLES-1);
    end else if ((state_r == SETTLE) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture, response valid and completion counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_x_r      <= 64'd0;
      rsp_y_r      <= 64'd0;
      rsp_z_r      <= 64'd0;
      rsp_valid_r  <= 1'b0;
      conv_count_r <= '0;
    end else if ((state_r == SETTLE) && (cnt_r == 4'd0)) begin
      rsp_x_r     <= dp_X;
      rsp_y_r     <= dp_Y;
      rsp_z_r     <= dp_Z;
      rsp_valid_r <= 1'b1;
    end else if (rsp_hs_s) begin
      rsp_valid_r  <= 1'b0;
      conv_count_r <= conv_count_r + CNT_W'(1);
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign dp_R       = dp_r_r;
  assign dp_G       = dp_g_r;
  assign dp_B       = dp_b_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_X      = rsp_x_r;
  assign rsp_Y      = rsp_y_r;
  assign rsp_Z      = rsp_z_r;
  assign rsp_valid  = rsp_valid_r;
  assign busy       = (state_r != IDLE);
  assign conv_count = conv_count_r;

endmodule

// File: tb/tb_xyz_convert_scheduler.sv
module tb_xyz_convert_scheduler;
  import xyz_sched_pkg::*;

  localparam int NR = 2;
  localparam int SC = 4;
  localparam int CW = 4;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*64-1:0]  req_R, req_G, req_B;
  logic [63:0]       dp_R, dp_G, dp_B, dp_X, dp_Y, dp_Z;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_X, rsp_Y, rsp_Z;
  logic [CW-1:0]     conv_count;
  logic [63:0]       x_mask;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stub datapath: identity, with an optional late toggle on X.
  assign dp_X = dp_R ^ x_mask;
  assign dp_Y = dp_G;
  assign dp_Z = dp_B;

  xyz_convert_scheduler #(.NUM_REQ(NR), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_R(req_R), .req_G(req_G), .req_B(req_B),
    .dp_R(dp_R), .dp_G(dp_G), .dp_B(dp_B),
    .dp_X(dp_X), .dp_Y(dp_Y), .dp_Z(dp_Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_X(rsp_X), .rsp_Y(rsp_Y), .rsp_Z(rsp_Z),
    .busy(busy), .conv_count(conv_count)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
        check("rsp_X", rsp_X, e.x);
        check("rsp_Y", rsp_Y, e.y);
        check("rsp_Z", rsp_Z, e.z);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [63:0] r, input logic [63:0] g, input logic [63:0] b);
    req_R[i*64 +: 64] = r;
    req_G[i*64 +: 64] = g;
    req_B[i*64 +: 64] = b;
  endtask

  // Issue one request and push its expected response on acceptance.
  task automatic do_req(input int i, input logic [63:0] r, input logic [63:0] g, input logic [63:0] b);
    int n;
    bit ok;
    set_ops(i, r, g, b);
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 40 && !ok; n++) begin
      @(negedge Clk);
      if (req_ready[i] === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid[i] = 1'b0;
    end else begin
      exp_q.push_back('{id: 2'(i), x: r, y: g, z: b});
      tick();
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n, last_cyc;
    logic [NR-1:0] exp_gnt [4];
    logic [63:0] rv;

    Reset_n   = 1'b0;
    req_valid = '0;
    req_R = '0; req_G = '0; req_B = '0;
    rsp_ready = 1'b1;
    x_mask    = 64'd0;

    // Reset state
    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_dp_R", dp_R, 64'd0);
    check("rst_conv_count", {60'd0, conv_count}, 64'd0);
    tick(); tick();
    Reset_n = 1'b1;
    tick();

    // Single request, latency 4 edges
    set_ops(0, DBL_ONE, DBL_ONE, DBL_ONE);
    req_valid[0] = 1'b1;
    @(negedge Clk);
    check("single_ready", {62'd0, req_ready}, 64'd1);
    exp_q.push_back('{id: 2'd0, x: DBL_ONE, y: DBL_ONE, z: DBL_ONE});
    tick();
    req_valid[0] = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'd4);
    tick();
    check("single_count", {60'd0, conv_count}, 64'd1);
    check("single_busy", {63'd0, busy}, 64'd0);

    // Backpressure on requester 1
    rsp_ready = 1'b0;
    do_req(1, DBL_HALF, DBL_ONE, 64'h4000000000000000);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid", {63'd0, rsp_valid}, 64'd1);
    req_valid[0] = 1'b1;
    set_ops(0, 64'h1111, 64'h2222, 64'h3333);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_rsp_X", rsp_X, DBL_HALF);
      check("bp_rsp_id", {62'd0, rsp_id}, 64'd1);
      check("bp_req_ready", {62'd0, req_ready}, 64'd0);
      check("bp_busy", {63'd0, busy}, 64'd1);
    end
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    check("bp_idle", {63'd0, busy}, 64'd0);
    check("bp_count", {60'd0, conv_count}, 64'd2);
    check("bp_X_kept", rsp_X, DBL_HALF);

    // Settle window: datapath output toggles after 3 edges
    rv = 64'h0123456789ABCDEF;
    set_ops(0, rv, 64'h0A0A, 64'h0B0B);
    req_valid[0] = 1'b1;
    @(negedge Clk);
    check("settle_ready", {62'd0, req_ready}, 64'd1);
    exp_q.push_back('{id: 2'd0, x: rv ^ 64'hFFFF000000000000, y: 64'h0A0A, z: 64'h0B0B});
    tick();
    req_valid[0] = 1'b0;
    set_ops(0, 64'h5555, 64'h6666, 64'h7777);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("settle_dp_R", dp_R, rv);
    end
    x_mask = 64'hFFFF000000000000;
    tick();
    check("settle_valid", {63'd0, rsp_valid}, 64'd1);
    check("settle_dp_R_end", dp_R, rv);
    tick();
    x_mask = 64'd0;
    check("settle_count", {60'd0, conv_count}, 64'd3);

    // Reset mid-SETTLE drops the request
    set_ops(1, 64'h9999, 64'h8888, 64'h7777);
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tick();
    Reset_n = 1'b0;
    #1;
    check("midrst_dp_R", dp_R, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_rsp_X", rsp_X, 64'd0);
    check("midrst_count", {60'd0, conv_count}, 64'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("postrst_busy", {63'd0, busy}, 64'd0);

    // Contention: grant order 0,1,0,1 six cycles apart
    set_ops(0, 64'h3FF0000000000000, 64'h10, 64'h20);
    set_ops(1, 64'h4008000000000000, 64'h30, 64'h40);
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back('{id: 2'd0, x: 64'h3FF0000000000000, y: 64'h10, z: 64'h20});
      else            exp_q.push_back('{id: 2'd1, x: 64'h4008000000000000, y: 64'h30, z: 64'h40});
    end
    req_valid = 2'b11;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge Clk);
      while (req_ready === 2'b00 && n < 30) begin
        @(negedge Clk);
        n++;
      end
      check("cont_grant", {62'd0, req_ready}, {62'd0, exp_gnt[k]});
      if (k > 0) check("cont_interval", 64'(cyc - last_cyc), 64'd6);
      last_cyc = cyc;
    end
    tick();
    req_valid = 2'b00;
    wait_idle();
    check("cont_count", {60'd0, conv_count}, 64'd4);

    // Counter wrap: 17 conversions from reset
    do_reset();
    for (int k = 0; k < 17; k++) begin
      do_req(k % 2, 64'(k), 64'(k + 100), 64'(k + 200));
      wait_idle();
    end
    check("wrap_count", {60'd0, conv_count}, 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
